// File: rtl/reduce_kask_pipe.sv
// Pipelined LENGTH-bit AND/OR/XOR/NAND reduction, CHUNK bits folded per stage,
// with a valid/ready handshake and a single global stall on both sides.
module reduce_kask_pipe #(
  parameter int LENGTH = 16,
  parameter int CHUNK  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LENGTH-1:0] x,
  input  logic [1:0]        op,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              y,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam int STAGES = (LENGTH + CHUNK - 1) / CHUNK;
  localparam int PADLEN = STAGES * CHUNK;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  function automatic logic seed_of(input op_e o);
    return (o == OP_AND) || (o == OP_NAND);
  endfunction

  // NAND folds as AND; inversion happens only when the result is registered.
  function automatic logic fold(input op_e o, input logic a, input logic [CHUNK-1:0] b);
    case (o)
      OP_OR:   return a | (|b);
      OP_XOR:  return a ^ (^b);
      default: return a & (&b);
    endcase
  endfunction

  function automatic logic finish(input op_e o, input logic a);
    return (o == OP_NAND) ? ~a : a;
  endfunction

  // Triangular skew store: stage k keeps chunks k+1..STAGES-1, packed back to back.
  function automatic int skew_off(input int k);
    return k * (STAGES - 1) * CHUNK - CHUNK * ((k * (k - 1)) / 2);
  endfunction

  logic              en;
  op_e               op_in;
  logic [PADLEN-1:0] x_pad;
  logic              y_q, y_d;
  logic              y_valid_q, y_valid_d;

  assign en      = ~y_valid_q | y_ready;
  assign x_ready = en;
  assign op_in   = op_e'(op);
  assign y       = y_q;
  assign y_valid = y_valid_q;

  // Missing top bits take the identity of the captured op so they never affect the result.
  always_comb begin
    x_pad             = {PADLEN{seed_of(op_in)}};
    x_pad[LENGTH-1:0] = x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
    end else if (en) begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      always_comb begin
        y_valid_d = x_valid;
        y_d       = x_valid ? finish(op_in, fold(op_in, seed_of(op_in), x_pad)) : y_q;
      end
    end else begin : g_pipe
      localparam int SKW = skew_off(STAGES - 1);

      logic [STAGES-2:0] valid_q, valid_d;
      logic [STAGES-2:0] acc_q, acc_d;
      op_e               op_q [STAGES-1];
      op_e               op_d [STAGES-1];
      logic [SKW-1:0]    skew_q, skew_d;

      always_comb begin
        valid_d = valid_q;
        acc_d   = acc_q;
        op_d    = op_q;
        skew_d  = skew_q;

        valid_d[0] = x_valid;
        op_d[0]    = op_in;
        acc_d[0]   = fold(op_in, seed_of(op_in), x_pad[CHUNK-1:0]);
        for (int unsigned c = 1; c < STAGES; c++) begin
          skew_d[skew_off(0) + (c - 1) * CHUNK +: CHUNK] = x_pad[c * CHUNK +: CHUNK];
        end

        for (int unsigned k = 1; k < STAGES - 1; k++) begin
          valid_d[k] = valid_q[k-1];
          op_d[k]    = op_q[k-1];
          acc_d[k]   = fold(op_q[k-1], acc_q[k-1], skew_q[skew_off(k - 1) +: CHUNK]);
          for (int unsigned c = k + 1; c < STAGES; c++) begin
            skew_d[skew_off(k) + (c - k - 1) * CHUNK +: CHUNK] =
              skew_q[skew_off(k - 1) + (c - k) * CHUNK +: CHUNK];
          end
        end

        y_valid_d = valid_q[STAGES-2];
        y_d       = valid_q[STAGES-2]
                  ? finish(op_q[STAGES-2],
                           fold(op_q[STAGES-2], acc_q[STAGES-2],
                                skew_q[skew_off(STAGES - 2) +: CHUNK]))
                  : y_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
          acc_q   <= '0;
          skew_q  <= '0;
          for (int unsigned k = 0; k < STAGES - 1; k++) begin
            op_q[k] <= OP_AND;
          end
        end else if (en) begin
          valid_q <= valid_d;
          acc_q   <= acc_d;
          skew_q  <= skew_d;
          op_q    <= op_d;
        end
      end
    end
  endgenerate

endmodule
